// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types and defaults for the decode-to-execute operand stage.
package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;
  localparam int CPU_CTRL_W = 8;

  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

endpackage

// File: rtl/id_ex_operand_stage_bypass.sv
// Writeback match/mux for one operand: substitutes write data on an index match,
// pins register zero to 0, or passes the input through when bypass is disabled.
module id_ex_bypass
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter bit EN     = 1'b1
) (
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    if (EN) begin
      if (idx == ADDR_W'(REG_ZERO)) begin
        data_out = '0;
      end else if (wb_we && (wb_reg == idx)) begin
        data_out = wb_data;
      end
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: 2-entry skid buffer with writeback bypass at capture and on
// held entries. Bypass/refresh is compiled in only when IDEX_WB_BYPASS_EN is defined.
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int CTRL_W = CPU_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              InValid,
  output logic              InReady,
  input  logic [ADDR_W-1:0] Rs,
  input  logic [ADDR_W-1:0] Rt,
  input  logic [ADDR_W-1:0] Rd,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [DATA_W-1:0] Imm,
  input  logic [CTRL_W-1:0] Ctrl,
  input  logic              Flush,
  input  logic              WbRegWrite,
  input  logic [ADDR_W-1:0] WbWriteReg,
  input  logic [DATA_W-1:0] WbWriteData,
  output logic              ExValid,
  input  logic              ExReady,
  output logic [DATA_W-1:0] ExA,
  output logic [DATA_W-1:0] ExB,
  output logic [DATA_W-1:0] ExImm,
  output logic [ADDR_W-1:0] ExRd,
  output logic [CTRL_W-1:0] ExCtrl
);

`ifdef IDEX_WB_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  stage_state_t state_q, state_d;
  entry_t       main_q, main_d, skid_q, skid_d;
  entry_t       cap, main_ref, skid_ref;
  logic         accept, emit;

  // Capture path: new operands with writeback forwarding
  id_ex_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .EN(BypassEn)) u_cap_a (
    .idx(Rs), .data_in(ReadData1), .wb_we(WbRegWrite), .wb_reg(WbWriteReg),
    .wb_data(WbWriteData), .data_out(cap.a));
  id_ex_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .EN(BypassEn)) u_cap_b (
    .idx(Rt), .data_in(ReadData2), .wb_we(WbRegWrite), .wb_reg(WbWriteReg),
    .wb_data(WbWriteData), .data_out(cap.b));

  id_ex_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .EN(BypassEn)) u_main_a (
    .idx(main_q.rs), .data_in(main_q.a), .wb_we(WbRegWrite), .wb_reg(WbWriteReg),
    .wb_data(WbWriteData), .data_out(main_ref.a));
  id_ex_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .EN(BypassEn)) u_main_b (
    .idx(main_q.rt), .data_in(main_q.b), .wb_we(WbRegWrite), .wb_reg(WbWriteReg),
    .wb_data(WbWriteData), .data_out(main_ref.b));
  id_ex_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .EN(BypassEn)) u_skid_a (
    .idx(skid_q.rs), .data_in(skid_q.a), .wb_we(WbRegWrite), .wb_reg(WbWriteReg),
    .wb_data(WbWriteData), .data_out(skid_ref.a));
  id_ex_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .EN(BypassEn)) u_skid_b (
    .idx(skid_q.rt), .data_in(skid_q.b), .wb_we(WbRegWrite), .wb_reg(WbWriteReg),
    .wb_data(WbWriteData), .data_out(skid_ref.b));

  assign cap.imm  = Imm;
  assign cap.rs   = Rs;
  assign cap.rt   = Rt;
  assign cap.rd   = Rd;
  assign cap.ctrl = Ctrl;

  assign main_ref.imm  = main_q.imm;
  assign main_ref.rs   = main_q.rs;
  assign main_ref.rt   = main_q.rt;
  assign main_ref.rd   = main_q.rd;
  assign main_ref.ctrl = main_q.ctrl;
  assign skid_ref.imm  = skid_q.imm;
  assign skid_ref.rs   = skid_q.rs;
  assign skid_ref.rt   = skid_q.rt;
  assign skid_ref.rd   = skid_q.rd;
  assign skid_ref.ctrl = skid_q.ctrl;

  assign InReady = (state_q != TWO);
  assign ExValid = (state_q != EMPTY);
  assign ExA     = main_q.a;
  assign ExB     = main_q.b;
  assign ExImm   = main_q.imm;
  assign ExRd    = main_q.rd;
  assign ExCtrl  = main_q.ctrl;

  // An instruction presented during a flush is dropped, never captured
  always_comb begin
    accept  = InValid && (state_q != TWO) && !Flush;
    emit    = (state_q != EMPTY) && ExReady;
    state_d = state_q;
    main_d  = main_ref;
    skid_d  = skid_ref;
    if (Flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = cap;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && !emit) begin
            skid_d  = cap;
            state_d = TWO;
          end else if (accept && emit) begin
            main_d = cap;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (emit) begin
            main_d  = skid_ref;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: driver pushes expected entries on accept,
// monitor pops and compares on every emit.
module tb_id_ex_operand_stage;

`ifdef IDEX_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        InValid, InReady;
  logic [4:0]  Rs, Rt, Rd;
  logic [31:0] ReadData1, ReadData2, Imm;
  logic [7:0]  Ctrl;
  logic        Flush;
  logic        WbRegWrite;
  logic [4:0]  WbWriteReg;
  logic [31:0] WbWriteData;
  logic        ExValid, ExReady;
  logic [31:0] ExA, ExB, ExImm;
  logic [4:0]  ExRd;
  logic [7:0]  ExCtrl;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  exp_t q[$];
  int acc_log[$];
  int emit_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Imm(Imm), .Ctrl(Ctrl), .Flush(Flush), .WbRegWrite(WbRegWrite),
    .WbWriteReg(WbWriteReg), .WbWriteData(WbWriteData), .ExValid(ExValid),
    .ExReady(ExReady), .ExA(ExA), .ExB(ExB), .ExImm(ExImm), .ExRd(ExRd),
    .ExCtrl(ExCtrl));

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [4:0] rd,
                              input logic [7:0] ctrl);
    exp_t e;
    e.a = a; e.b = b; e.imm = imm; e.rd = rd; e.ctrl = ctrl;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every emit must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && ExValid && ExReady) begin
      emit_log.push_back(cyc);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_emit: got A=%h B=%h Rd=%h expected no emit", ExA, ExB, ExRd);
      end else begin
        e = q.pop_front();
        if ({ExA, ExB, ExImm, ExRd, ExCtrl} !== e) begin
          errors++;
          $display("FAIL emit_data: got A=%h B=%h Imm=%h Rd=%h Ctrl=%h expected A=%h B=%h Imm=%h Rd=%h Ctrl=%h",
                   ExA, ExB, ExImm, ExRd, ExCtrl, e.a, e.b, e.imm, e.rd, e.ctrl);
        end
      end
    end
  end

  task automatic send(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [31:0] rd1, input logic [31:0] rd2,
                      input logic [31:0] imm, input logic [7:0] ctrl, input exp_t e);
    Rs = rs; Rt = rt; Rd = rd; ReadData1 = rd1; ReadData2 = rd2; Imm = imm; Ctrl = ctrl;
    InValid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (InReady) begin
        q.push_back(e);
        acc_log.push_back(cyc + 1);
        @(posedge clk);
        #1;
        InValid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got InReady=0 for 50 cycles expected 1");
    InValid = 1'b0;
  endtask

  task automatic drain(input string name);
    ExReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk(name, q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_inready"}, InReady, 1);
    chk({tag, "_exvalid"}, ExValid, 0);
    chk({tag, "_exa"}, ExA, 0);
    chk({tag, "_exb"}, ExB, 0);
    chk({tag, "_eximm"}, ExImm, 0);
    chk({tag, "_exrd"}, ExRd, 0);
    chk({tag, "_exctrl"}, ExCtrl, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; InValid = 1'b0; Rs = '0; Rt = '0; Rd = '0;
    ReadData1 = '0; ReadData2 = '0; Imm = '0; Ctrl = '0; Flush = 1'b0;
    WbRegWrite = 1'b0; WbWriteReg = '0; WbWriteData = '0; ExReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset_init");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stream of 4 with ExReady held high
    ExReady = 1'b1;
    acc_log.delete();
    emit_log.delete();
    for (int i = 0; i < 4; i++) begin
      send(5'(i + 1), 5'(i + 9), 5'(i + 16), 32'h1000 + i, 32'h2000 + i,
           32'hFFFF_FFF0 + i, 8'hA0 + 8'(i),
           mk(32'h1000 + i, 32'h2000 + i, 32'hFFFF_FFF0 + i, 5'(i + 16), 8'hA0 + 8'(i)));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("stream_emit_count", emit_log.size(), 4);
    if (emit_log.size() == 4 && acc_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("stream_latency", emit_log[i], acc_log[i]);
        chk("stream_consecutive", emit_log[i], emit_log[0] + i);
      end
    end
    drain("stream_drain");

    // Backpressure: two held, third waits until execute resumes
    ExReady = 1'b0;
    send(5'd1, 5'd2, 5'd3, 32'hB1, 32'hC1, 32'h1, 8'h11, mk(32'hB1, 32'hC1, 32'h1, 5'd3, 8'h11));
    chk("bp_inready_one", InReady, 1);
    send(5'd4, 5'd5, 5'd6, 32'hB2, 32'hC2, 32'h2, 8'h22, mk(32'hB2, 32'hC2, 32'h2, 5'd6, 8'h22));
    chk("bp_inready_two", InReady, 0);
    chk("bp_exvalid", ExValid, 1);
    chk("bp_hold_a", ExA, 32'hB1);
    fork
      send(5'd7, 5'd8, 5'd9, 32'hB3, 32'hC3, 32'h3, 8'h33, mk(32'hB3, 32'hC3, 32'h3, 5'd9, 8'h33));
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("bp_still_held_a", ExA, 32'hB1);
        ExReady = 1'b1;
      end
    join
    drain("bp_drain");

    // Capture bypass and register-zero forcing
    ExReady = 1'b1;
    WbRegWrite = 1'b1; WbWriteReg = 5'd5; WbWriteData = 32'hAB;
    send(5'd5, 5'd6, 5'd1, 32'h11, 32'h22, 32'h4, 8'h44,
         mk(BYP ? 32'hAB : 32'h11, 32'h22, 32'h4, 5'd1, 8'h44));
    WbRegWrite = 1'b0;
    drain("cap_drain");
    WbRegWrite = 1'b1; WbWriteReg = 5'd0; WbWriteData = 32'hFF;
    send(5'd0, 5'd3, 5'd2, 32'h77, 32'h33, 32'h5, 8'h55,
         mk(BYP ? 32'h0 : 32'h77, 32'h33, 32'h5, 5'd2, 8'h55));
    WbRegWrite = 1'b0;
    drain("zero_drain");

    // Refresh of a held entry
    ExReady = 1'b0;
    send(5'd2, 5'd7, 5'd4, 32'h200, 32'h55, 32'h6, 8'h66,
         mk(32'h200, BYP ? 32'h1234 : 32'h55, 32'h6, 5'd4, 8'h66));
    WbRegWrite = 1'b1; WbWriteReg = 5'd7; WbWriteData = 32'h1234;
    @(posedge clk);
    #1;
    WbRegWrite = 1'b0;
    @(negedge clk);
    chk("refresh_exb", ExB, BYP ? 32'h1234 : 32'h55);
    chk("refresh_exa", ExA, 32'h200);
    chk("refresh_exvalid", ExValid, 1);
    @(posedge clk);
    #1;
    drain("refresh_drain");

    // Flush while TWO with a new instruction offered
    ExReady = 1'b0;
    send(5'd1, 5'd1, 5'd10, 32'hD1, 32'hE1, 32'h7, 8'h77, mk(32'hD1, 32'hE1, 32'h7, 5'd10, 8'h77));
    send(5'd2, 5'd2, 5'd11, 32'hD2, 32'hE2, 32'h8, 8'h88, mk(32'hD2, 32'hE2, 32'h8, 5'd11, 8'h88));
    Rs = 5'd3; Rt = 5'd3; Rd = 5'd12; ReadData1 = 32'hDEAD; ReadData2 = 32'hBEEF;
    Imm = 32'h9; Ctrl = 8'h99; InValid = 1'b1; Flush = 1'b1;
    @(posedge clk);
    #1;
    Flush = 1'b0;
    InValid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("flush_exvalid", ExValid, 0);
    chk("flush_inready", InReady, 1);
    @(posedge clk);
    #1;
    ExReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(5'd4, 5'd5, 5'd13, 32'hF1, 32'hF2, 32'hA, 8'hAA, mk(32'hF1, 32'hF2, 32'hA, 5'd13, 8'hAA));
    drain("flush_drain");

    // Asynchronous reset while two entries are held
    ExReady = 1'b0;
    send(5'd1, 5'd2, 5'd14, 32'h31, 32'h32, 32'hB, 8'hBB, mk(32'h31, 32'h32, 32'hB, 5'd14, 8'hBB));
    send(5'd3, 5'd4, 5'd15, 32'h41, 32'h42, 32'hC, 8'hCC, mk(32'h41, 32'h42, 32'hC, 5'd15, 8'hCC));
    chk("rst_pre_inready", InReady, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_mid");
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    ExReady = 1'b1;
    send(5'd6, 5'd7, 5'd16, 32'h51, 32'h52, 32'hD, 8'hDD, mk(32'h51, 32'h52, 32'hD, 5'd16, 8'hDD));
    drain("post_reset_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
